// File: rtl/snn_neuron_rr.sv
// Integrate-and-fire neuron: round-robin event arbiter, signed weight RAM, and a saturating
// leaky membrane with a refractory period. The weight image is loaded through the write port.
module snn_neuron_rr #(
   parameter int N_IN       = 16,
   parameter int IDX_W      = 4,
   parameter int ADDR_W     = 4,
   parameter int W_BITS     = 8,
   parameter int V_BITS     = 12,
   parameter int THETA      = 511,
   parameter int REFRACT    = 10,
   parameter int LEAK_SHIFT = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [N_IN-1:0]           spikes_in,
   output logic [N_IN-1:0]           acks_out,
   input  logic [N_IN*ADDR_W-1:0]    addr_in,
   input  logic                      timer_en,
   output logic                      spike_out,
   input  logic                      ack_in,
   output logic                      spike_drop,
   input  logic                      wr_en,
   input  logic [IDX_W+ADDR_W-1:0]   wr_addr,
   input  logic [W_BITS-1:0]         wr_data
);

   localparam int RAM_AW = IDX_W + ADDR_W;
   localparam int DEPTH  = N_IN << ADDR_W;
   localparam int S      = V_BITS + 2;
   localparam int REF_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

   localparam logic [V_BITS-1:0] THETA_V   = V_BITS'(THETA);
   localparam logic [REF_W-1:0]  REFRACT_V = REF_W'(REFRACT);
   localparam logic [IDX_W:0]    N_IN_W    = (IDX_W+1)'(N_IN);
   localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(N_IN - 1);

   logic [N_IN-1:0]   acks_q, acks_d, eligible;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, grant;
   logic              grant_vld;
   logic [ADDR_W-1:0] grant_syn;
   logic [RAM_AW-1:0] rd_idx;
   logic              valid_q;
   logic [W_BITS-1:0] rd_data_q;
   logic [W_BITS-1:0] mem [DEPTH];
   logic [V_BITS-1:0] v_q, v_d;
   logic [REF_W-1:0]  ref_cnt_q;
   logic              spike_q, drop_q;
   logic              fire;
   logic signed [S-1:0] v_ext, leak, w_ext, sum;

   // A channel acked this cycle still shows its request, so it is masked out.
   always_comb begin
      logic [IDX_W:0] cand;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      eligible  = spikes_in & ~acks_q;
      grant_vld = 1'b0;
      grant     = '0;
      cand      = '0;
      for (int i = 0; i < N_IN; i++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
         if (cand >= N_IN_W) cand = cand - N_IN_W;
         if (!grant_vld && eligible[cand[IDX_W-1:0]]) begin
            grant_vld = 1'b1;
            grant     = cand[IDX_W-1:0];
         end
      end
      acks_d        = '0;
      acks_d[grant] = grant_vld;
      rr_ptr_d      = (grant == LAST_CH) ? '0 : grant + IDX_W'(1);
      grant_syn     = addr_in[grant*ADDR_W +: ADDR_W];
      rd_idx        = {grant, grant_syn};
   end

   // NOTE: the weight RAM and its read register carry no reset; weights survive resetn and
   // stale read data is harmless because valid_q gates it.
   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;
      rd_data_q <= mem[rd_idx];
   end

   // Membrane arithmetic is done two bits wider and signed, then clamped to [0, 2^V_BITS-1].
   always_comb begin
      v_ext = signed'({2'b00, v_q});
      leak  = (timer_en && LEAK_SHIFT != 0) ? signed'({2'b00, v_q >> LEAK_SHIFT}) : '0;
      w_ext = valid_q ? {{(S-W_BITS){rd_data_q[W_BITS-1]}}, rd_data_q} : '0;
      sum   = v_ext - leak + w_ext;
      if (sum[S-1])      v_d = '0;
      else if (sum[S-2]) v_d = '1;
      else               v_d = sum[V_BITS-1:0];
   end

   assign fire = (ref_cnt_q == '0) && (v_q > THETA_V);

   // NOTE: sequential state is updated only with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         acks_q    <= '0;
         rr_ptr_q  <= '0;
         valid_q   <= 1'b0;
         v_q       <= '0;
         ref_cnt_q <= '0;
         spike_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         acks_q  <= acks_d;
         valid_q <= grant_vld;
         drop_q  <= 1'b0;
         if (grant_vld) rr_ptr_q <= rr_ptr_d;
         if (fire) begin
            v_q       <= '0;
            ref_cnt_q <= REFRACT_V;
            spike_q   <= 1'b1;
            drop_q    <= spike_q;
         end else begin
            if (ack_in) spike_q <= 1'b0;
            if (ref_cnt_q != '0) begin
               v_q <= '0;
               if (timer_en) ref_cnt_q <= ref_cnt_q - REF_W'(1);
            end else begin
               v_q <= v_d;
            end
         end
      end
   end

   assign acks_out   = acks_q;
   assign spike_out  = spike_q;
   assign spike_drop = drop_q;

endmodule

// File: tb/tb_snn_neuron_rr.sv
// Directed bench for snn_neuron_rr: a default-threshold instance plus a THETA=4095 instance
// sharing the same stimulus, used to reach the upper saturation bound without firing.
module tb_snn_neuron_rr;

   localparam int N_IN   = 16;
   localparam int IDX_W  = 4;
   localparam int ADDR_W = 4;
   localparam int W_BITS = 8;
   localparam int V_BITS = 12;

   logic                    clk = 1'b0;
   logic                    resetn;
   logic [N_IN-1:0]         spikes_in;
   logic [N_IN*ADDR_W-1:0]  addr_in;
   logic                    timer_en, ack_in, wr_en;
   logic [IDX_W+ADDR_W-1:0] wr_addr;
   logic [W_BITS-1:0]       wr_data;
   logic [N_IN-1:0]         acks_out, acks_hi;
   logic                    spike_out, spike_drop, spike_hi, drop_hi;
   logic [N_IN-1:0]         seen_mask;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   snn_neuron_rr #(
      .N_IN(N_IN), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .W_BITS(W_BITS), .V_BITS(V_BITS),
      .THETA(511), .REFRACT(10), .LEAK_SHIFT(4)
   ) dut (
      .clk(clk), .resetn(resetn), .spikes_in(spikes_in), .acks_out(acks_out),
      .addr_in(addr_in), .timer_en(timer_en), .spike_out(spike_out), .ack_in(ack_in),
      .spike_drop(spike_drop), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   snn_neuron_rr #(
      .N_IN(N_IN), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .W_BITS(W_BITS), .V_BITS(V_BITS),
      .THETA(4095), .REFRACT(10), .LEAK_SHIFT(4)
   ) dut_hi (
      .clk(clk), .resetn(resetn), .spikes_in(spikes_in), .acks_out(acks_hi),
      .addr_in(addr_in), .timer_en(timer_en), .spike_out(spike_hi), .ack_in(ack_in),
      .spike_drop(drop_hi), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int syn, input int val);
      wr_en   = 1'b1;
      wr_addr = {IDX_W'(ch), ADDR_W'(syn)};
      wr_data = W_BITS'(val);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      spikes_in = '0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   // One upstream event: raise request, wait (bounded) for its ack, drop, then let it integrate.
   task automatic send(input int ch, input int syn);
      bit seen;
      seen = 1'b0;
      addr_in[ch*ADDR_W +: ADDR_W] = ADDR_W'(syn);
      spikes_in[ch] = 1'b1;
      for (int k = 0; k < 8 && !seen; k++) begin
         tick();
         if (acks_out[ch]) seen = 1'b1;
      end
      spikes_in[ch] = 1'b0;
      check("ack_seen", 32'(seen), 32'd1);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with garbage on the inputs.
      resetn    = 1'b0;
      spikes_in = 16'hA5C3;
      addr_in   = 64'h0123_4567_89AB_CDEF;
      timer_en  = 1'b1;
      ack_in    = 1'b1;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      tick();
      tick();
      check("rst_acks", 32'(acks_out), 32'h0);
      check("rst_spike", 32'(spike_out), 32'd0);
      check("rst_drop", 32'(spike_drop), 32'd0);
      check("rst_v", 32'(dut.v_q), 32'd0);

      spikes_in = '0;
      addr_in   = '0;
      timer_en  = 1'b0;
      ack_in    = 1'b0;
      for (int a = 0; a < N_IN * 16; a++) wr(a / 16, a % 16, 0);
      wr(0, 0, 100);

      resetn    = 1'b1;
      addr_in[0 +: ADDR_W] = 4'd15;
      spikes_in = 16'h0001;
      tick();
      check("first_ack", 32'(acks_out), 32'h0001);
      spikes_in = '0;
      tick();
      check("ack_one_cycle", 32'(acks_out), 32'h0000);
      check("v_zero_weight", 32'(dut.v_q), 32'd0);

      // Round-robin between the two ends of the channel range.
      do_reset();
      addr_in   = '0;
      spikes_in = 16'h8001;
      tick();
      check("rr_first", 32'(acks_out), 32'h0001);
      spikes_in[0] = 1'b0;
      tick();
      check("rr_second", 32'(acks_out), 32'h8000);
      spikes_in[15] = 1'b0;
      tick();
      tick();

      // All channels requesting continuously: one grant per cycle, rotating 0..15.
      do_reset();
      addr_in   = '0;
      seen_mask = '0;
      spikes_in = 16'hFFFF;
      for (int i = 0; i < N_IN; i++) begin
         tick();
         check("rr_rotate", 32'(acks_out), 32'h1 << i);
         seen_mask = seen_mask | acks_out;
      end
      check("rr_all_seen", 32'(seen_mask), 32'hFFFF);
      spikes_in = '0;
      tick();
      tick();

      // Integrate to threshold and fire.
      do_reset();
      for (int e = 0; e < 5; e++) send(0, 0);
      check("v_500", 32'(dut.v_q), 32'd500);
      check("no_fire_500", 32'(spike_out), 32'd0);
      send(0, 0);
      check("v_600", 32'(dut.v_q), 32'd600);
      tick();
      check("fire_spike", 32'(spike_out), 32'd1);
      check("fire_v0", 32'(dut.v_q), 32'd0);
      check("fire_ref", 32'(dut.ref_cnt_q), 32'd10);

      // Refractory: events are acked but discarded; countdown on timer ticks only.
      for (int e = 0; e < 5; e++) send(0, 0);
      check("refr_v0", 32'(dut.v_q), 32'd0);
      check("refr_hold", 32'(dut.ref_cnt_q), 32'd10);
      timer_en = 1'b1;
      for (int t = 0; t < 9; t++) tick();
      check("refr_9", 32'(dut.ref_cnt_q), 32'd1);
      tick();
      timer_en = 1'b0;
      check("refr_done", 32'(dut.ref_cnt_q), 32'd0);
      wr(0, 1, 56);
      send(0, 0);
      send(0, 0);
      send(0, 1);
      check("v_256", 32'(dut.v_q), 32'd256);
      timer_en = 1'b1;
      tick();
      timer_en = 1'b0;
      check("leak_240", 32'(dut.v_q), 32'd240);

      // Lower saturation bound.
      do_reset();
      wr(1, 2, 50);
      wr(1, 3, -128);
      send(1, 2);
      check("v_50", 32'(dut.v_q), 32'd50);
      send(1, 3);
      check("sat_low", 32'(dut.v_q), 32'd0);

      // Upper saturation bound on the high-threshold instance.
      do_reset();
      wr(2, 0, 127);
      wr(2, 1, 26);
      for (int e = 0; e < 32; e++) send(2, 0);
      check("hi_4064", 32'(dut_hi.v_q), 32'd4064);
      send(2, 1);
      check("hi_4090", 32'(dut_hi.v_q), 32'd4090);
      send(2, 0);
      check("sat_high", 32'(dut_hi.v_q), 32'd4095);
      tick();
      check("hi_no_fire", 32'(spike_hi), 32'd0);

      // Output handshake and drop detection.
      do_reset();
      for (int e = 0; e < 6; e++) send(0, 0);
      tick();
      check("hs_fire1", 32'(spike_out), 32'd1);
      check("hs_nodrop1", 32'(spike_drop), 32'd0);
      timer_en = 1'b1;
      for (int t = 0; t < 10; t++) tick();
      timer_en = 1'b0;
      for (int e = 0; e < 6; e++) send(0, 0);
      tick();
      check("hs_drop", 32'(spike_drop), 32'd1);
      check("hs_held", 32'(spike_out), 32'd1);
      tick();
      check("hs_drop_pulse", 32'(spike_drop), 32'd0);
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      check("hs_acked", 32'(spike_out), 32'd0);
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      check("hs_idle_ack", 32'(spike_out), 32'd0);
      timer_en = 1'b1;
      for (int t = 0; t < 10; t++) tick();
      timer_en = 1'b0;
      for (int e = 0; e < 6; e++) send(0, 0);
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      check("hs_fire_ack", 32'(spike_out), 32'd1);
      check("hs_fire_ack_nodrop", 32'(spike_drop), 32'd0);

      // RAM write, then a read of an address written in the same cycle returns old data.
      do_reset();
      wr(3, 5, 20);
      send(3, 5);
      check("ram_v20", 32'(dut.v_q), 32'd20);
      wr(3, 6, 7);
      addr_in[3*ADDR_W +: ADDR_W] = 4'd6;
      spikes_in[3] = 1'b1;
      wr_en   = 1'b1;
      wr_addr = {4'd3, 4'd6};
      wr_data = 8'd30;
      tick();
      wr_en = 1'b0;
      check("ram_rw_ack", 32'(acks_out), 32'h0008);
      spikes_in[3] = 1'b0;
      tick();
      check("ram_old_data", 32'(dut.v_q), 32'd27);
      send(3, 6);
      check("ram_new_data", 32'(dut.v_q), 32'd57);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
